// File: rtl/rgb_pkg.sv
// Shared types for the RGB fade controller: channel encodings and FSM states.
package rgb_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    CH_R    = 2'd0,
    CH_G    = 2'd1,
    CH_B    = 2'd2,
    CH_RSVD = 2'd3
  } ch_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2
  } state_e;

endpackage

// File: rtl/rgb_fade_if.sv
// Sample handshake between a target source (master) and the fade controller (slave).
interface rgb_fade_if #(
  parameter int CTR_LEN = 8
);
  logic               sample_valid;
  logic [1:0]         sample_ch;
  logic [CTR_LEN-1:0] sample_data;
  logic               sample_ready;

  modport master (
    output sample_valid, sample_ch, sample_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid, sample_ch, sample_data,
    output sample_ready
  );
endinterface

// File: rtl/fade_step.sv
// One-LSB move of a channel's current value toward its target when enabled.
module fade_step #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] nxt
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // NOTE: assign a default before any branch so a missed path cannot infer a latch.
  always_comb begin
    nxt = cur;
    if (en) begin
      // Strict comparisons stop exactly on the target: no overshoot, no wrap.
      if (cur < tgt) begin
        nxt = cur + ONE;
      end else if (cur > tgt) begin
        nxt = cur - ONE;
      end
    end
  end
endmodule

// File: rtl/rgb_fade_ctrl.sv
// Three-channel fade controller: accepts per-channel targets, ramps current values one
// LSB per prescaler tick, and presents period-aligned compare values to external PWMs.
module rgb_fade_ctrl
  import rgb_pkg::*;
#(
  parameter int CTR_LEN = 8,
  parameter int DIV_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rgb_fade_if.slave          smp,
  output logic [CTR_LEN-1:0] cmp_r,
  output logic [CTR_LEN-1:0] cmp_g,
  output logic [CTR_LEN-1:0] cmp_b,
  output logic               period_end,
  output logic               busy
);
  localparam logic [CTR_LEN-1:0] CTR_ONE = {{(CTR_LEN-1){1'b0}}, 1'b1};
  localparam logic [DIV_LEN-1:0] DIV_ONE = {{(DIV_LEN-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [DIV_LEN-1:0]   div_q, div_d;
  logic [CTR_LEN-1:0]   per_q, per_d;
  logic [CTR_LEN-1:0]   tgt_q [NUM_CH];
  logic [CTR_LEN-1:0]   tgt_d [NUM_CH];
  logic [CTR_LEN-1:0]   cur_q [NUM_CH];
  logic [CTR_LEN-1:0]   cur_d [NUM_CH];
  logic [CTR_LEN-1:0]   cmp_q [NUM_CH];
  logic [CTR_LEN-1:0]   cmp_d [NUM_CH];
  logic [CTR_LEN-1:0]   step_nxt [NUM_CH];
  logic [NUM_CH-1:0]    ch_diff;
  logic                 any_diff;
  logic                 accept;
  logic                 step_en;

  assign accept   = smp.sample_valid & ready_q;
  assign any_diff = |ch_diff;
  // Ticks landing in LOAD are dropped rather than queued.
  assign step_en  = (state_q == RAMP) && (&div_q);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_diff[g] = (cur_q[g] != tgt_q[g]);

    fade_step #(.W(CTR_LEN)) u_fade_step (
      .en  (step_en),
      .cur (cur_q[g]),
      .tgt (tgt_q[g]),
      .nxt (step_nxt[g])
    );
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = any_diff ? RAMP : IDLE;
      RAMP: begin
        if (accept) begin
          state_d = LOAD;
        end else if (!any_diff) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is a flop so the handshake never depends combinationally on sample_valid.
    ready_d = (state_d != LOAD);
  end

  // Datapath: counters, targets, current values and compare shadows.
  always_comb begin
    div_d = div_q + DIV_ONE;
    per_d = per_q + CTR_ONE;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = tgt_q[i];
      cur_d[i] = step_nxt[i];
      cmp_d[i] = period_end ? cur_q[i] : cmp_q[i];
      // The reserved channel matches no index, so it is accepted and dropped.
      if (accept && (smp.sample_ch == i[1:0])) begin
        tgt_d[i] = smp.sample_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      div_q   <= '0;
      per_q   <= '0;
      // NOTE: the small per-channel register arrays are reset because clearing them is part of the reset contract.
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
        cmp_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      div_q   <= div_d;
      per_q   <= per_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
        cmp_q[i] <= cmp_d[i];
      end
    end
  end

  assign smp.sample_ready = ready_q;
  assign period_end       = &per_q;
  assign busy             = any_diff;
  assign cmp_r            = cmp_q[0];
  assign cmp_g            = cmp_q[1];
  assign cmp_b            = cmp_q[2];

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Scoreboard bench for rgb_fade_ctrl: driver pushes expected settled compare triplets,
// a monitor pops them when the DUT reports idle at a period boundary.
module tb_rgb_fade_ctrl;
  import rgb_pkg::*;

  localparam int CTR_LEN   = 8;
  localparam int DIV_LEN   = 4;
  localparam int STEP      = 1 << DIV_LEN;
  localparam int PERIOD    = 1 << CTR_LEN;
  localparam int MAX_LAT   = STEP + PERIOD + 2;
  localparam int SETTLE_TO = 6000;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } trip_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] cmp_r, cmp_g, cmp_b;
  logic       period_end, busy;

  rgb_fade_if #(.CTR_LEN(CTR_LEN)) smp ();

  rgb_fade_ctrl #(.CTR_LEN(CTR_LEN), .DIV_LEN(DIV_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smp        (smp),
    .cmp_r      (cmp_r),
    .cmp_g      (cmp_g),
    .cmp_b      (cmp_b),
    .period_end (period_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_tgt [3];
  trip_t exp_q [$];
  trip_t cur_exp;
  bit    pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: when idle at a period end, cmp takes the settled values next edge.
  always @(negedge clk) begin
    if (pending) begin
      check("settled_cmp_r", cmp_r, cur_exp.r);
      check("settled_cmp_g", cmp_g, cur_exp.g);
      check("settled_cmp_b", cmp_b, cur_exp.b);
      pending = 1'b0;
    end else if (rst_n && exp_q.size() > 0 && !busy && period_end) begin
      cur_exp = exp_q.pop_front();
      pending = 1'b1;
    end
  end

  // Compare outputs may only move on the edge closing a period; a down-ramp on R stays monotonic.
  logic [7:0] pr = '0, pg = '0, pb = '0;
  logic       ppe = 1'b0, prst = 1'b0;
  int         pe_viol = 0, mono_viol = 0;
  bit         mono_en = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prst) begin
      if ({cmp_r, cmp_g, cmp_b} != {pr, pg, pb} && !ppe) pe_viol++;
      if (mono_en && (cmp_r > pr || (int'(pr) - int'(cmp_r)) > PERIOD / STEP || cmp_r < 8'h10))
        mono_viol++;
    end
    pr = cmp_r; pg = cmp_g; pb = cmp_b; ppe = period_end; prst = rst_n;
  end

  // Offer one sample; returns the accepting cycle index, or -1 on timeout.
  task automatic send(input logic [1:0] ch, input logic [7:0] d, output int acc);
    smp.sample_valid = 1'b1;
    smp.sample_ch    = ch;
    smp.sample_data  = d;
    acc = -1;
    for (int i = 0; i < 8; i++) begin
      if (smp.sample_ready) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    smp.sample_valid = 1'b0;
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    else if (ch != 2'd3) m_tgt[ch] = int'(d);
  endtask

  task automatic push_exp();
    trip_t t;
    t.r = m_tgt[0][7:0];
    t.g = m_tgt[1][7:0];
    t.b = m_tgt[2][7:0];
    exp_q.push_back(t);
  endtask

  task automatic wait_settle(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || pending) && n < SETTLE_TO) begin
      @(negedge clk);
      n++;
    end
    check({name, "_settled_in_time"}, 32'(n < SETTLE_TO), 32'd1);
    if (n >= SETTLE_TO) begin
      exp_q.delete();
      pending = 1'b0;
    end
  endtask

  initial begin
    int         acc, acc0, acc1, acc2, n, gap;
    logic [1:0] ch;
    logic [7:0] d;
    logic       b0;

    smp.sample_valid = 1'b0;
    smp.sample_ch    = 2'd0;
    smp.sample_data  = 8'd0;
    foreach (m_tgt[i]) m_tgt[i] = 0;

    #1 rst_n = 1'b0;
    #3;
    check("reset_ready", smp.sample_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_period_end", period_end, 1'b0);
    check("reset_cmp", {cmp_r, cmp_g, cmp_b}, 24'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_release", smp.sample_ready, 1'b1);

    // R=0x80 offered at cycle 5.
    do @(negedge clk); while (cyc < 4);
    send(2'd0, 8'h80, acc);
    check("r80_accept_cycle", acc, 5);
    check("r80_ready_low_in_load", smp.sample_ready, 1'b0);
    check("r80_busy_high", busy, 1'b1);
    push_exp();
    n = 0;
    while (cmp_r == 8'd0 && n < MAX_LAT + 20) begin
      @(negedge clk);
      n++;
    end
    check("r80_first_cmp_latency_ok", 32'((cmp_r != 8'd0) && (cyc - acc <= MAX_LAT)), 32'd1);
    wait_settle("r80");
    check("r80_busy_low_after", busy, 1'b0);

    // Down-ramp 0x20 -> 0x10.
    send(2'd0, 8'h20, acc);
    push_exp();
    wait_settle("r20");
    mono_en = 1'b1;
    send(2'd0, 8'h10, acc);
    push_exp();
    wait_settle("r10");
    mono_en = 1'b0;
    check("r10_monotonic_no_underflow", mono_viol, 0);

    // Reserved channel is accepted and discarded.
    b0 = busy;
    send(2'd3, 8'hFF, acc);
    check("rsvd_handshake", 32'(acc >= 0), 32'd1);
    check("rsvd_busy_unchanged", busy, b0);
    push_exp();
    wait_settle("rsvd");

    // Back-to-back R, G, B.
    send(2'd0, 8'($urandom), acc0);
    send(2'd1, 8'($urandom), acc1);
    send(2'd2, 8'($urandom), acc2);
    check("b2b_gap_rg", acc1 - acc0, 2);
    check("b2b_gap_gb", acc2 - acc1, 2);
    push_exp();
    wait_settle("b2b");

    // Random groups, including retargets of channels still ramping.
    for (int g = 0; g < 8; g++) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        ch  = 2'($urandom_range(0, 3));
        d   = 8'($urandom);
        gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 200));
        repeat (gap) @(negedge clk);
        send(ch, d, acc);
      end
      push_exp();
      wait_settle("rand_group");
    end

    // Asynchronous reset in the middle of a long ramp.
    d = (m_tgt[0] >= 128) ? 8'h00 : 8'hFF;
    send(2'd0, d, acc);
    repeat ($urandom_range(20, 300)) @(negedge clk);
    check("busy_before_reset", busy, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", smp.sample_ready, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_period_end", period_end, 1'b0);
    check("async_rst_cmp", {cmp_r, cmp_g, cmp_b}, 24'd0);
    foreach (m_tgt[i]) m_tgt[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_mid_ramp_reset", smp.sample_ready, 1'b1);

    @(negedge clk);
    send(2'd1, 8'h33, acc);
    push_exp();
    wait_settle("post_reset");

    check("cmp_changes_only_after_period_end", pe_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_fade_ctrl.md
RGB_FADE_CTRL -- requirements
Module: rgb_fade_ctrl

Interface
REQ-001 Parameter CTR_LEN, default 8, SHALL set the width of PWM compare values and of the period counter.
REQ-002 Parameter DIV_LEN, default 4, SHALL set the width of the fade-step prescaler; one fade step every 2^DIV_LEN clocks.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 sample_valid  input  1  SHALL indicate that a new channel target is offered.
REQ-006 sample_ch  input  2  SHALL select the target channel: 0=R, 1=G, 2=B, 3=reserved.
REQ-007 sample_data  input  CTR_LEN  SHALL carry the target duty value.
REQ-008 sample_ready  output  1  SHALL indicate that a sample can be accepted this cycle.
REQ-009 cmp_r, cmp_g, cmp_b  output  CTR_LEN each  SHALL drive the compare inputs of three pwm instances.
REQ-010 period_end  output  1  SHALL pulse for one cycle when the internal period counter is at all-ones.
REQ-011 busy  output  1  SHALL be high while any channel's current value differs from its target.

Function
REQ-012 A sample SHALL be accepted when sample_valid and sample_ready are both high on a rising edge.
REQ-013 FSM states SHALL be IDLE, LOAD, RAMP; reset state IDLE.
REQ-014 On acceptance from IDLE or RAMP, the FSM SHALL enter LOAD for exactly one cycle and write sample_data into the selected target register; sample_ch=3 SHALL be accepted and discarded, with no register change.
REQ-015 sample_ready SHALL be registered: low in LOAD and during reset, high in IDLE and RAMP.
REQ-016 Exiting LOAD, the FSM SHALL enter RAMP if any current differs from its target, otherwise IDLE; RAMP SHALL return to IDLE on the cycle after all channels match.
REQ-017 The prescaler SHALL free-run modulo 2^DIV_LEN; on its all-ones cycle in RAMP, each current value SHALL move one LSB toward its target, with no overshoot and no wrap.
REQ-018 A step tick coinciding with LOAD SHALL be skipped, not deferred.
REQ-019 The period counter SHALL free-run modulo 2^CTR_LEN in lockstep with the pwm counters, all released from reset on the same edge.
REQ-020 cmp_r/g/b SHALL be shadow registers loaded from the current values only on the period_end cycle, so a compare never changes mid-period.
REQ-021 Latency from acceptance to first cmp change SHALL be at most 2^DIV_LEN + 2^CTR_LEN + 2 cycles.
REQ-022 A new target for a channel already ramping SHALL retarget from its present current value, with no restart from zero.

Reset
REQ-023 Asserting rst_n low SHALL immediately clear all targets, current values, cmp_r/g/b, both counters, period_end, busy and sample_ready, and force IDLE, including mid-ramp or in LOAD.
REQ-024 After deassertion, the first rising edge SHALL set sample_ready high.

Structure
REQ-025 Channel encodings (CH_R, CH_G, CH_B, CH_RSVD) and the FSM state type SHALL reside in the shared package rgb_pkg.
REQ-026 The per-channel step-toward-target logic SHALL be one sub-module, fade_step, instantiated three times.
REQ-027 The pwm block SHALL remain outside this controller; the top level SHALL connect the cmp outputs to it.

Verification
REQ-028 Reset release, then R=0x80 offered at cycle 5 -> accepted at cycle 5, sample_ready low at cycle 6, busy high, cmp_r reaching 0x80 after 128 steps, busy then low.
REQ-029 R target 0x10 from current 0x20 -> cmp_r decreases monotonically by at most 1 per step, ending at exactly 0x10 with no underflow.
REQ-030 cmp_g updates sampled every cycle -> changes only on period_end cycles.
REQ-031 sample_ch=3 with data 0xFF -> handshake completes, all targets unchanged, busy unchanged.
REQ-032 rst_n low mid-ramp at an arbitrary cycle -> all outputs 0 asynchronously, before the next edge; sample_ready 1 one edge after release.
REQ-033 Back-to-back valid samples on R, G, B -> every second cycle accepted, and all three reach targets independently.
